// File: rtl/tl_demand_ctrl.sv
// Demand-actuated NS/EW traffic light controller with pedestrian walk phase.
// Latency: state/timer advance on the clock edge of an i_tick cycle; outputs are registered.
// Backpressure: none; i_tick low freezes sequencing while requests keep latching.
//
// Ports:
//   i_clk, i_rst_n   clock (rising edge), asynchronous active-low reset
//   i_tick           1-cycle time-base strobe; all durations counted in ticks
//   i_req_ns/ew      vehicle sensors (level)
//   i_ped_req        pedestrian button (pulse, >= 1 cycle)
//   o_state          light code: 111 START, 011 NS, 010 NY, 100 NAR,
//                    000 EW, 001 EY, 101 EAR
//   o_walk           pedestrian walk lamp
//   o_phase_t        ticks elapsed in the current state (saturating)
module tl_demand_ctrl #(
    parameter int T_WIDTH    = 8,
    parameter int START_TIME = 3,
    parameter int MIN_GREEN  = 4,
    parameter int MAX_GREEN  = 10,
    parameter int Y_TIME     = 3,
    parameter int AR_TIME    = 1,
    parameter int PED_TIME   = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_tick,
    input  logic               i_req_ns,
    input  logic               i_req_ew,
    input  logic               i_ped_req,
    output logic [2:0]         o_state,
    output logic               o_walk,
    output logic [T_WIDTH-1:0] o_phase_t
);

    typedef enum logic [2:0] {
        ST_START = 3'b111,
        ST_NS    = 3'b011,
        ST_NY    = 3'b010,
        ST_NAR   = 3'b100,
        ST_EW    = 3'b000,
        ST_EY    = 3'b001,
        ST_EAR   = 3'b101
    } state_t;

    // n = t+1 is carried one bit wider so a saturated timer still compares
    // correctly against the thresholds.
    localparam int N_W = T_WIDTH + 1;
    localparam logic [N_W-1:0]     START_N = N_W'(START_TIME);
    localparam logic [N_W-1:0]     MIN_N   = N_W'(MIN_GREEN);
    localparam logic [N_W-1:0]     MAX_N   = N_W'(MAX_GREEN);
    localparam logic [N_W-1:0]     Y_N     = N_W'(Y_TIME);
    localparam logic [N_W-1:0]     AR_N    = N_W'(AR_TIME);
    localparam logic [T_WIDTH-1:0] PED_T   = T_WIDTH'(PED_TIME);
    localparam logic [T_WIDTH-1:0] T_MAX   = '1;

    state_t               state_q, state_d;
    logic [T_WIDTH-1:0]   t_q, t_d;
    logic [N_W-1:0]       n;
    logic                 dem_ew_q, dem_ew_d;
    logic                 dem_ns_q, dem_ns_d;
    logic                 ped_pend_q, ped_pend_d;
    logic                 ped_walk_q, ped_walk_d;
    logic                 walk_d;
    logic                 state_chg, enter_ns, enter_ew;

    assign n = {1'b0, t_q} + N_W'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_START;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_START: if (i_tick && n == START_N) state_d = ST_NS;
            ST_NS: begin
                if (i_tick && dem_ew_q && ((n >= MIN_N && !i_req_ns) || n >= MAX_N))
                    state_d = ST_NY;
            end
            ST_NY:  if (i_tick && n == Y_N)  state_d = ST_NAR;
            ST_NAR: if (i_tick && n == AR_N) state_d = ST_EW;
            ST_EW: begin
                if (i_tick && dem_ns_q && ((n >= MIN_N && !i_req_ew) || n >= MAX_N))
                    state_d = ST_EY;
            end
            ST_EY:  if (i_tick && n == Y_N)  state_d = ST_EAR;
            ST_EAR: if (i_tick && n == AR_N) state_d = ST_NS;
            // Unused code recovers to START regardless of the tick.
            default: state_d = ST_START;
        endcase
    end

    always_comb begin
        state_chg = (state_d != state_q);
        enter_ns  = state_chg && (state_d == ST_NS);
        enter_ew  = state_chg && (state_d == ST_EW);

        if (state_chg)
            t_d = '0;
        else if (i_tick && t_q != T_MAX)
            t_d = t_q + T_WIDTH'(1);
        else
            t_d = t_q;

        // A request arriving on the same edge as the clear keeps the latch set.
        if (state_q != ST_EW && (i_req_ew || i_ped_req))
            dem_ew_d = 1'b1;
        else if (enter_ew)
            dem_ew_d = 1'b0;
        else
            dem_ew_d = dem_ew_q;

        if (state_q != ST_NS && i_req_ns)
            dem_ns_d = 1'b1;
        else if (enter_ns)
            dem_ns_d = 1'b0;
        else
            dem_ns_d = dem_ns_q;

        if (i_ped_req)
            ped_pend_d = 1'b1;
        else if (enter_ew)
            ped_pend_d = 1'b0;
        else
            ped_pend_d = ped_pend_q;

        // Walk eligibility is frozen at EW entry, including a pulse on that edge.
        ped_walk_d = enter_ew ? (ped_pend_q || i_ped_req) : ped_walk_q;

        walk_d = (state_d == ST_EW) && ped_walk_d && (t_d < PED_T);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            t_q        <= '0;
            dem_ew_q   <= 1'b0;
            dem_ns_q   <= 1'b0;
            ped_pend_q <= 1'b0;
            ped_walk_q <= 1'b0;
            o_walk     <= 1'b0;
        end else begin
            t_q        <= t_d;
            dem_ew_q   <= dem_ew_d;
            dem_ns_q   <= dem_ns_d;
            ped_pend_q <= ped_pend_d;
            ped_walk_q <= ped_walk_d;
            o_walk     <= walk_d;
        end
    end

    assign o_state   = state_q;
    assign o_phase_t = t_q;

endmodule

// File: tb/tb_tl_demand_ctrl.sv
module tb_tl_demand_ctrl;

    localparam int TW   = 8;
    localparam int STT  = 3;
    localparam int MING = 4;
    localparam int MAXG = 10;
    localparam int YT   = 3;
    localparam int ART  = 1;
    localparam int PT   = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tick;
    logic          req_ns;
    logic          req_ew;
    logic          ped_req;
    logic [2:0]    state;
    logic          walk;
    logic [TW-1:0] phase_t;

    always #5 clk = ~clk;

    tl_demand_ctrl #(
        .T_WIDTH(TW), .START_TIME(STT), .MIN_GREEN(MING), .MAX_GREEN(MAXG),
        .Y_TIME(YT), .AR_TIME(ART), .PED_TIME(PT)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_tick    (tick),
        .i_req_ns  (req_ns),
        .i_req_ew  (req_ew),
        .i_ped_req (ped_req),
        .o_state   (state),
        .o_walk    (walk),
        .o_phase_t (phase_t)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase index in the light cycle NS,NY,NAR,EW,EY,EAR
    // (-1 is START), unbounded tick count, and the request bookkeeping.
    int m_ph;
    int m_t;
    bit m_dem_ew, m_dem_ns, m_ped, m_pw;

    function automatic int code_of(input int ph);
        case (ph)
            0:       return 3'b011;
            1:       return 3'b010;
            2:       return 3'b100;
            3:       return 3'b000;
            4:       return 3'b001;
            5:       return 3'b101;
            default: return 3'b111;
        endcase
    endfunction

    task automatic model_reset();
        m_ph = -1; m_t = 0;
        m_dem_ew = 0; m_dem_ns = 0; m_ped = 0; m_pw = 0;
    endtask

    task automatic model_step(input bit tk, input bit rns, input bit rew, input bit ped);
        int  nxt;
        int  n;
        bit  entered, into_ew, into_ns;
        nxt = m_ph;
        n   = m_t + 1;
        if (tk) begin
            case (m_ph)
                -1:   if (n == STT) nxt = 0;
                0:    if (m_dem_ew && ((n >= MING && !rns) || n >= MAXG)) nxt = 1;
                3:    if (m_dem_ns && ((n >= MING && !rew) || n >= MAXG)) nxt = 4;
                1, 4: if (n == YT) nxt = m_ph + 1;
                default: if (n == ART) nxt = (m_ph + 1) % 6;
            endcase
        end
        entered = (nxt != m_ph);
        into_ew = entered && nxt == 3;
        into_ns = entered && nxt == 0;
        if (into_ew) m_pw = m_ped || ped;
        if (m_ph != 3 && (rew || ped)) m_dem_ew = 1; else if (into_ew) m_dem_ew = 0;
        if (m_ph != 0 && rns)          m_dem_ns = 1; else if (into_ns) m_dem_ns = 0;
        if (ped) m_ped = 1; else if (into_ew) m_ped = 0;
        if (entered)   m_t = 0;
        else if (tk && m_t < 100000) m_t = m_t + 1;
        m_ph = nxt;
    endtask

    task automatic check_outputs();
        int exp_t;
        exp_t = (m_t > 255) ? 255 : m_t;
        check_val("state",   int'(state),   code_of(m_ph));
        check_val("phase_t", int'(phase_t), exp_t);
        check_val("walk",    int'(walk),    int'(m_ph == 3 && m_pw && m_t < PT));
    endtask

    // Called at posedge+1: assert reset between edges, check the immediate
    // effect, hold across one edge, then release away from the edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
    endtask

    int ncyc, p_flip, p_ped;
    bit tk;

    initial begin
        rst_n = 1'b0; tick = 1'b0; req_ns = 1'b0; req_ew = 1'b0; ped_req = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;

        for (int sc = 0; sc < 5; sc++) begin
            req_ns = 1'b0; req_ew = 1'b0; ped_req = 1'b0; tick = 1'b0;
            do_reset();
            case (sc)
                0:       begin ncyc = 300;  p_flip = 0; p_ped = 0;  end
                1:       begin ncyc = 1500; p_flip = 5; p_ped = 2;  end
                2:       begin ncyc = 1500; p_flip = 3; p_ped = 2;  end
                3:       begin ncyc = 1500; p_flip = 8; p_ped = 5;  end
                default: begin ncyc = 1500; p_flip = 2; p_ped = 15; end
            endcase
            for (int cyc = 0; cyc < ncyc; cyc++) begin
                case (sc)
                    2:       tk = (cyc % 4 == 0);
                    3:       tk = bit'($urandom_range(0, 1));
                    default: tk = 1'b1;
                endcase
                tick = tk;
                if ($urandom_range(0, 99) < p_flip) req_ns = ~req_ns;
                if ($urandom_range(0, 99) < p_flip) req_ew = ~req_ew;
                ped_req = ($urandom_range(0, 99) < p_ped);
                @(posedge clk);
                model_step(tick, req_ns, req_ew, ped_req);
                #1;
                check_outputs();
                if (sc >= 1 && m_ph == 4 && $urandom_range(0, 9) == 0)
                    do_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
